enum_index_arbiter: RTL

ENUM_INDEX_ARBITER -- requirements
Module: enum_index_arbiter

---
 rtl/enum_index_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/enum_index_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : enum_index_arbiter
// Purpose  : Round-robin arbiter sharing one read port of a 4-entry table,
//            indexed by a clamped enum selector, with a 1-deep output register.
// Revision : 1.0 - initial release
// ============================================================================
module enum_index_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_sel,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 wr_en,
  input  logic [1:0]           wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [DATA_W-1:0]    rsp_data,
  input  logic                 rsp_ready
);

  localparam int c_ENTRIES = 4;

  logic [DATA_W-1:0] r_table [c_ENTRIES];
  logic [1:0]        r_rr_ptr;
  logic              r_rsp_valid;
  logic [1:0]        r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;

  logic [3:0]        w_valid_pad;
  logic [7:0]        w_sel_pad;
  logic [2:0]        w_sum;
  logic [1:0]        w_cand;
  logic [1:0]        w_grant;
  logic              w_any;
  logic              w_free;
  logic              w_accept;
  logic [3:0]        w_onehot;
  logic [1:0]        w_sel;
  logic [2:0]        w_idx_sum;
  logic [1:0]        w_rd_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic [1:0]        w_next_ptr;

  // Pad request vectors to the 4-requester maximum so 2-bit indices stay legal.
  assign w_valid_pad = 4'(req_valid);
  assign w_sel_pad   = 8'(req_sel);

  // Scan from the highest offset down so the nearest valid requester wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + 3'(k);
      if (w_sum >= 3'(NUM_REQ)) begin
        w_sum = w_sum - 3'(NUM_REQ);
      end
      w_cand = w_sum[1:0];
      if (w_valid_pad[w_cand]) begin
        w_any   = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  assign w_free    = ~r_rsp_valid | rsp_ready;
  assign w_accept  = w_free & w_any & rst_n;
  assign w_onehot  = 4'b0001 << w_grant;
  assign req_ready = w_accept ? w_onehot[NUM_REQ-1:0] : '0;

  assign w_sel      = w_sel_pad[{w_grant, 1'b0} +: 2];
  assign w_idx_sum  = {1'b0, w_sel} + 3'd1;
  assign w_rd_idx   = (w_idx_sum > 3'd3) ? 2'd3 : w_idx_sum[1:0];
  assign w_rd_data  = r_table[w_rd_idx];
  assign w_next_ptr = (w_grant == 2'(NUM_REQ - 1)) ? 2'd0 : w_grant + 2'd1;

  // The read above sees the pre-write contents of a same-cycle write target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_table[i] <= '0;
      end
    end else if (wr_en) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (w_accept) begin
      r_rr_ptr    <= w_next_ptr;
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_grant;
      r_rsp_data  <= w_rd_data;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire
